mem_rw_arbiter: RTL
===================

# mem_rw_arbiter

Round-robin arbiter that shares the single read port and single write port of the simulation memory helper (`MemRWHelper`) among `NUM_REQ` requesters. It serialises one memory operation per cycle, tracks the 1-cycle read latency, and returns tagged read data through a credit-protected response FIFO with valid/ready backpressure. It sits between the SoC-side memory clients (e.g. the AXI-to-mem bridge and DMA/loader) and the `MemRWHelper` instance.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `RESP_DEPTH`, default 2: response FIFO entries, at least 2.

Ports:
- `clock`, input, 1: the only clock.
- `reset_n`, input, 1: asynchronous active-low reset.
- `req_valid`, input, NUM_REQ: per-requester request valid.
- `req_ready`, output, NUM_REQ: one-hot grant; a request is accepted when valid & ready.
- `req_write`, input, NUM_REQ: 1 = write, 0 = read.
- `req_index`, input, NUM_REQ*64: 64-bit word index per requester.
- `req_wdata`, input, NUM_REQ*64: write data.
- `req_wmask`, input, NUM_REQ*64: bit write mask.
- `resp_valid`, output, 1: read response available.
- `resp_ready`, input, 1: response consumer ready.
- `resp_id`, output, log2(NUM_REQ): requester that issued the read.
- `resp_data`, output, 64: read data.
- `mem_r_enable`, output, 1: to the memory helper read port.
- `mem_r_index`, output, 64: to the memory helper read port.
- `mem_r_data`, input, 64: from the memory helper read port.
- `mem_w_enable`, output, 1: to the memory helper write port.
- `mem_w_index`, output, 64: to the memory helper write port.
- `mem_w_data`, output, 64: to the memory helper write port.
- `mem_w_mask`, output, 64: to the memory helper write port.

## Operation

- **Arbitration**
  - At most one grant per cycle, to a read or a write.
  - Round-robin: search starts at `(last_granted+1) mod NUM_REQ`. After reset, `last_granted = NUM_REQ-1`, so requester 0 has first priority.
- **Eligibility**
  - A write request is always eligible.
  - A read request is eligible only when `inflight + fifo_count - pop < RESP_DEPTH`.
    - `inflight` is 1 if a read was issued last cycle.
    - `pop = resp_valid & resp_ready`.
  - Ineligible requesters are skipped without losing their priority turn.
- **Write**
  - Drive `mem_w_enable=1` and index/data/mask from the winner in the grant cycle, combinationally.
  - No response is returned.
- **Read**
  - Drive `mem_r_enable=1` and `mem_r_index` in grant cycle T.
  - Register `inflight=1` and the winner's id.
  - At T+1, push `{id, mem_r_data}` into the FIFO.
- **Response FIFO**
  - `resp_*` outputs are taken from the FIFO head.
  - Push and pop in the same cycle are allowed, including when the FIFO is full, because the credit rule already accounts for the pop.
  - Overflow is impossible by construction.
- **Ordering**
  - Responses are returned in issue order.
  - A read granted in the cycle after a write to the same index returns the new data.
- **Start-up gate**
  - A registered `run` flag resets to 0 and becomes 1 on the first clock edge after `reset_n` deasserts.
  - While `run=0`, `req_ready=0` and all `mem_*_enable` outputs are 0.
- **Reset mid-operation**
  - The in-flight read is discarded, the FIFO is emptied and the pointer is reinitialised.
  - Requesters must reissue.

## Timing

- Reset values:
  - `req_ready=0`, `resp_valid=0`, `resp_id=0`, `resp_data=0`.
  - `mem_r_enable=0`, `mem_w_enable=0`; memory index/data/mask outputs 0.
- `req_ready` and `mem_*` request outputs are combinational from `req_valid` and state. `resp_*` outputs are registered.
- Read latency is 2 cycles from acceptance (T) to `resp_valid` (T+2), provided the FIFO is empty.
- Sustained throughput is 1 read/cycle with `RESP_DEPTH=2` while `resp_ready=1`.
- With `resp_ready=0`, at most `RESP_DEPTH` reads are outstanding; after that, reads stall and writes continue.
- Write throughput is 1/cycle.

## Configuration

- `MEM_RW_ARB_PERF_EN` defined:
  - Adds output `perf_grant_cnt`, width NUM_REQ*32: per-requester grant counters.
  - Adds output `perf_read_stall_cnt`, width 32: cycles in which a read was valid but blocked by credit.
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- Not defined: these ports and counters do not exist.

## Structure

- Package `mem_rw_arb_pkg` holds:
  - `MEM_IDX_W=64` and `MEM_DATA_W=64`.
  - The `resp_entry_t` struct `{id, data}`.
  - The round-robin next-grant function.
- Sub-module `mem_rw_arb_resp_fifo`: parameterised-depth synchronous FIFO of `resp_entry_t`, with count output, asynchronous active-low reset, and simultaneous push/pop.

## Test plan

- **Reset release:** hold all `req_valid=1` across reset deassertion → `req_ready=0` at the first edge; requester 0 is granted on the next cycle, then 1, 2, 3 in rotation.
- **Write then read, same index:** requester 1 writes index 0x10, data 0xDEADBEEF_00000000, mask 0xFFFFFFFF_00000000; requester 2 reads 0x10 the next cycle → `resp_valid` two cycles later with `resp_id=2` and upper word 0xDEADBEEF.
- **Backpressure:** `resp_ready=0`, 4 requesters issuing reads → exactly 2 reads granted; writes from another requester are still granted; after `resp_ready=1`, responses drain in issue order.
- **Full throughput:** requester 0 issues continuous reads with `resp_ready=1` → one grant per cycle and one `resp_valid` per cycle after 2 cycles of latency.
- **Reset mid-read:** assert `reset_n=0` the cycle after a read grant → no `resp_valid` after release and the FIFO count is 0.
- **Perf counters (`MEM_RW_ARB_PERF_EN`):** 10 grants to requester 3 → `perf_grant_cnt[3]=10`; preload 0xFFFFFFFE, then 3 grants → 0xFFFFFFFF.

Source files
------------

// File: rtl/mem_rw_arb_pkg.sv
// Shared types and helpers for the memory read/write arbiter:
// memory widths, the response FIFO entry and the round-robin picker.
package mem_rw_arb_pkg;

   localparam int MEM_IDX_W  = 64;
   localparam int MEM_DATA_W = 64;
   localparam int MAX_REQ    = 8;
   localparam int RESP_ID_W  = 3;

   // One queued read response: requester id plus the returned word.
   typedef struct packed {
      logic [RESP_ID_W-1:0]  id;
      logic [MEM_DATA_W-1:0] data;
   } resp_entry_t;

   typedef struct packed {
      logic                 found;
      logic [RESP_ID_W-1:0] idx;
   } rr_pick_t;

   // Round-robin winner: the first eligible requester at or after last+1
   // (mod num_req). The loop walks from farthest to nearest so the nearest
   // eligible candidate overwrites the others.
   function automatic rr_pick_t rr_next_grant(input logic [MAX_REQ-1:0]   elig,
                                              input logic [RESP_ID_W-1:0] last,
                                              input int unsigned          num_req);
      rr_pick_t               pick;
      logic [RESP_ID_W-1:0]   k;
      pick = '0;
      for (int unsigned i = MAX_REQ; i >= 1; i--) begin
         if (i <= num_req) begin
            k = RESP_ID_W'((32'(last) + i) % num_req);
            if (elig[k]) begin
               pick.found = 1'b1;
               pick.idx   = k;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mem_rw_arb_resp_fifo.sv
// Synchronous response FIFO of resp_entry_t with occupancy count.
// Push and pop may happen in the same cycle, including when full.
module mem_rw_arb_resp_fifo
   import mem_rw_arb_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  resp_entry_t       push_data_i,
   input  logic              pop_i,
   output resp_entry_t       head_o,
   output logic              head_vld_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   resp_entry_t      mem_q [DEPTH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Next pointers and occupancy.
   always_comb begin
      wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
   end

   // Control state; cleared by reset so a reset empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents only matter while counted, so no reset.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_vld_o = (count_q != '0);
   assign head_o     = head_vld_o ? mem_q[rd_ptr_q] : '0;
   assign count_o    = count_q;

endmodule

// File: rtl/mem_rw_arbiter.sv
// Round-robin arbiter sharing one memory read port and one write port
// among NUM_REQ requesters, returning tagged read data through a
// credit-protected response FIFO.
// Optional feature macro: MEM_RW_ARB_PERF_EN adds saturating grant and
// read-stall counters (perf_grant_cnt, perf_read_stall_cnt).
module mem_rw_arbiter
   import mem_rw_arb_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int RESP_DEPTH = 2,
   localparam int ID_W       = $clog2(NUM_REQ),
   localparam int CNT_W      = $clog2(RESP_DEPTH + 1),
   localparam int OCC_W      = CNT_W + 1
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*MEM_IDX_W-1:0]  req_index,
   input  logic [NUM_REQ*MEM_DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ*MEM_DATA_W-1:0] req_wmask,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [ID_W-1:0]               resp_id,
   output logic [MEM_DATA_W-1:0]         resp_data,
   output logic                          mem_r_enable,
   output logic [MEM_IDX_W-1:0]          mem_r_index,
   input  logic [MEM_DATA_W-1:0]         mem_r_data,
   output logic                          mem_w_enable,
   output logic [MEM_IDX_W-1:0]          mem_w_index,
   output logic [MEM_DATA_W-1:0]         mem_w_data,
   output logic [MEM_DATA_W-1:0]         mem_w_mask
`ifdef MEM_RW_ARB_PERF_EN
   ,
   output logic [NUM_REQ*32-1:0]         perf_grant_cnt,
   output logic [31:0]                   perf_read_stall_cnt
`endif
);

   logic                  run_q, run_d;
   logic [RESP_ID_W-1:0]  last_q, last_d;
   logic                  inflight_q, inflight_d;
   logic [RESP_ID_W-1:0]  inflight_id_q, inflight_id_d;
   logic [CNT_W-1:0]      fifo_count;
   logic [OCC_W-1:0]      occupancy;
   logic                  pop, credit_ok, grant_vld, grant_wr;
   logic [MAX_REQ-1:0]    elig;
   rr_pick_t              pick;
   logic [ID_W-1:0]       gidx;
   resp_entry_t           head, push_entry;
   logic                  unused_head_id;
   logic [MEM_IDX_W-1:0]  idx_a   [NUM_REQ];
   logic [MEM_DATA_W-1:0] wdata_a [NUM_REQ];
   logic [MEM_DATA_W-1:0] wmask_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign idx_a[g]   = req_index[g*MEM_IDX_W  +: MEM_IDX_W];
      assign wdata_a[g] = req_wdata[g*MEM_DATA_W +: MEM_DATA_W];
      assign wmask_a[g] = req_wmask[g*MEM_DATA_W +: MEM_DATA_W];
   end

   // Credit check and round-robin selection; a read needs a free FIFO slot
   // counting the read already in flight and any pop happening now.
   always_comb begin
      occupancy = OCC_W'(inflight_q) + OCC_W'(fifo_count) - OCC_W'(pop);
      credit_ok = (occupancy < OCC_W'(RESP_DEPTH));
      elig      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = req_valid[i] & (req_write[i] | credit_ok);
      end
      pick      = rr_next_grant(elig, last_q, NUM_REQ);
      gidx      = pick.idx[ID_W-1:0];
      grant_vld = run_q & pick.found;
      grant_wr  = req_write[gidx];
   end

   // Grant and memory-port drive for the winner of this cycle.
   always_comb begin
      req_ready    = '0;
      mem_r_enable = 1'b0;
      mem_r_index  = '0;
      mem_w_enable = 1'b0;
      mem_w_index  = '0;
      mem_w_data   = '0;
      mem_w_mask   = '0;
      if (grant_vld) begin
         req_ready[gidx] = 1'b1;
         if (grant_wr) begin
            mem_w_enable = 1'b1;
            mem_w_index  = idx_a[gidx];
            mem_w_data   = wdata_a[gidx];
            mem_w_mask   = wmask_a[gidx];
         end else begin
            mem_r_enable = 1'b1;
            mem_r_index  = idx_a[gidx];
         end
      end
   end

   // Next state: start-up gate, rotation pointer, and read-in-flight tag.
   always_comb begin
      run_d         = 1'b1;
      last_d        = grant_vld ? pick.idx : last_q;
      inflight_d    = mem_r_enable;
      inflight_id_d = grant_vld ? pick.idx : inflight_id_q;
   end

   // Arbiter control flops; reset drops any in-flight read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run_q         <= 1'b0;
         last_q        <= RESP_ID_W'(NUM_REQ - 1);
         inflight_q    <= 1'b0;
         inflight_id_q <= '0;
      end else begin
         run_q         <= run_d;
         last_q        <= last_d;
         inflight_q    <= inflight_d;
         inflight_id_q <= inflight_id_d;
      end
   end

   // Memory read data arrives one cycle after the grant and is queued.
   assign push_entry.id   = inflight_id_q;
   assign push_entry.data = mem_r_data;
   assign pop             = resp_valid & resp_ready;

   mem_rw_arb_resp_fifo #(
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clk         (clock),
      .rst_n       (reset_n),
      .push_i      (inflight_q),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .head_vld_o  (resp_valid),
      .count_o     (fifo_count)
   );

   assign resp_id        = head.id[ID_W-1:0];
   assign resp_data      = head.data;
   assign unused_head_id = ^head.id;

`ifdef MEM_RW_ARB_PERF_EN
   logic [31:0] grant_cnt_q [NUM_REQ];
   logic [31:0] grant_cnt_d [NUM_REQ];
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        read_blocked;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   // Saturating counters: per-requester grants and credit-blocked read cycles.
   always_comb begin
      read_blocked = run_q & (|(req_valid & ~req_write)) & ~credit_ok;
      stall_cnt_d  = sat_inc(stall_cnt_q, read_blocked);
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_cnt_d[i] = sat_inc(grant_cnt_q[i], req_ready[i]);
      end
   end

   // Counter flops, cleared by reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
      assign perf_grant_cnt[g*32 +: 32] = grant_cnt_q[g];
   end
   assign perf_read_stall_cnt = stall_cnt_q;
`endif

endmodule
